// File: rtl/base_res_arb_pkg.sv
// Types and helpers shared by the tag reservation arbiter and its round-robin core.
package base_res_arb_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/base_res_arb_rr.sv
// Round-robin selector: first set request at or after the pointer, wrapping to 0.
module base_rr_arb #(
    parameter  int ways = 4,
    localparam int PW   = (ways > 1) ? $clog2(ways) : 1
) (
    input  logic [0:ways-1] req,
    input  logic [PW-1:0]   ptr,
    output logic [0:ways-1] gnt
);

    int unsigned j;
    logic        found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < ways; i++) begin
            j = 32'(ptr) + i;
            if (j >= ways) j = j - ways;
            if (!found && req[j[PW-1:0]]) begin
                gnt[j[PW-1:0]] = 1'b1;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/base_res_arb.sv
// Hands out free tags from a pool to round-robin requesters and forwards legal tag frees back.
module base_res_arb
    import base_res_arb_pkg::*;
#(
    parameter int ways    = 4,
    parameter int width   = 4,
    parameter int num_res = 2**width
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:ways-1] req_v,
    output logic [0:ways-1] req_r,
    input  logic            p_v,
    output logic            p_r,
    input  logic [0:width-1] p_d,
    output logic            o_v,
    input  logic            o_r,
    output logic [0:width-1] o_d,
    output logic [0:ways-1] o_sel,
    input  logic            f_v,
    output logic            f_r,
    input  logic [0:width-1] f_d,
    output logic            r_v,
    input  logic            r_r,
    output logic [0:width-1] r_d,
    output logic [0:width]  o_cnt,
    output logic            o_err
);

    localparam int PW = (ways > 1) ? $clog2(ways) : 1;
    localparam logic [0:width] CNT_MAX = (width+1)'(num_res);

    out_state_e        state_q, state_d;
    logic [0:width-1]  od_q, od_d;
    logic [0:ways-1]   sel_q, sel_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [0:num_res-1] inuse_q, inuse_d;
    logic [0:width]    cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [0:ways-1]   rr_gnt;
    logic [PW-1:0]     win_idx;
    logic              loadable, grant, hit, fwd, drop;

    base_rr_arb #(.ways(ways)) u_rr (
        .req (req_v),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < ways; i++) begin
            if (rr_gnt[i[PW-1:0]]) win_idx = PW'(i);
        end
    end

    // Tags beyond the pool size are never in use, so freeing one is reported as illegal.
    assign hit = ({1'b0, f_d} < CNT_MAX) && inuse_q[f_d];

    always_comb begin
        loadable = (state_q == OUT_EMPTY) || o_r;
        grant    = !reset && loadable && p_v && (|req_v);
        p_r      = grant;
        req_r    = grant ? rr_gnt : '0;
        r_v      = !reset && f_v && hit;
        r_d      = f_d;
        f_r      = !reset && (hit ? r_r : 1'b1);
        fwd      = r_v && r_r;
        drop     = !reset && f_v && !hit;
    end

    always_comb begin
        state_d = state_q;
        od_d    = od_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        inuse_d = inuse_q;
        cnt_d   = cnt_q;
        err_d   = drop;
        if (grant) begin
            state_d = OUT_FULL;
            od_d    = p_d;
            sel_d   = rr_gnt;
            ptr_d   = PW'(wrap_inc(32'(win_idx), ways));
        end else if (o_r) begin
            state_d = OUT_EMPTY;
        end
        if (fwd)   inuse_d[f_d] = 1'b0;
        if (grant) inuse_d[p_d] = 1'b1;
        if (grant && !fwd && cnt_q != CNT_MAX) cnt_d = cnt_q + (width+1)'(1);
        else if (fwd && !grant)                cnt_d = cnt_q - (width+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            od_q    <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            inuse_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            od_q    <= od_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            inuse_q <= inuse_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_v   = (state_q == OUT_FULL);
    assign o_d   = od_q;
    assign o_sel = sel_q;
    assign o_cnt = cnt_q;
    assign o_err = err_q;

endmodule

// File: tb/tb_base_res_arb.sv
// Bench for base_res_arb: directed vector table, hand sequences and a random run against a reference model.
module tb_base_res_arb;

    localparam int WAYS = 4;
    localparam int W    = 4;
    localparam int NRES = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [0:WAYS-1] req_v, req_r;
    logic            p_v, p_r;
    logic [0:W-1]    p_d;
    logic            o_v, o_r;
    logic [0:W-1]    o_d;
    logic [0:WAYS-1] o_sel;
    logic            f_v, f_r;
    logic [0:W-1]    f_d;
    logic            r_v, r_r;
    logic [0:W-1]    r_d;
    logic [0:W]      o_cnt;
    logic            o_err;

    always #5 clk = ~clk;

    base_res_arb #(.ways(WAYS), .width(W), .num_res(NRES)) dut (
        .clk(clk), .reset(reset),
        .req_v(req_v), .req_r(req_r),
        .p_v(p_v), .p_r(p_r), .p_d(p_d),
        .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_sel(o_sel),
        .f_v(f_v), .f_r(f_r), .f_d(f_d),
        .r_v(r_v), .r_r(r_r), .r_d(r_d),
        .o_cnt(o_cnt), .o_err(o_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the block should remember between cycles.
    int m_ptr = 0;
    bit m_inuse[NRES];
    int m_cnt = 0;
    bit m_ov = 0;
    int m_od = 0;
    int m_sel = 0;
    bit m_err = 0;
    bit m_was_rst = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < WAYS; k++) begin
            int idx = (m_ptr + k) % WAYS;
            if (req_v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot(input int idx);
        return (idx < 0) ? 0 : (1 << (WAYS - 1 - idx));
    endfunction

    task automatic drive(input bit rst, input int req, input bit pv, input int pd, input bit orr,
                         input bit fv, input int fd, input bit rr);
        reset = rst;
        req_v = WAYS'(req);
        p_v   = pv;
        p_d   = W'(pd);
        o_r   = orr;
        f_v   = fv;
        f_d   = W'(fd);
        r_r   = rr;
    endtask

    // One clock: check handshake outputs, advance the model at the edge, then check registered outputs.
    task automatic tick();
        bit grant, hit, fwd;
        int w;
        #1;
        w     = winner();
        grant = !reset && (!m_ov || o_r) && p_v && (w >= 0);
        hit   = m_inuse[f_d];
        chk("req_r", int'(req_r), grant ? onehot(w) : 0);
        chk("p_r", int'(p_r), int'(grant));
        chk("r_v", int'(r_v), int'(!reset && f_v && hit));
        chk("f_r", int'(f_r), reset ? 0 : (hit ? int'(r_r) : 1));
        if (!reset && f_v && hit) chk("r_d", int'(r_d), int'(f_d));
        fwd = !reset && f_v && hit && r_r;
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_cnt = 0; m_ov = 0; m_od = 0; m_sel = 0; m_err = 0;
            foreach (m_inuse[i]) m_inuse[i] = 0;
            m_was_rst = 1;
        end else begin
            m_was_rst = 0;
            if (fwd) begin
                m_inuse[f_d] = 0;
                m_cnt--;
            end
            if (grant) begin
                m_inuse[p_d] = 1;
                if (m_cnt < NRES) m_cnt++;
            end
            m_err = f_v && !hit;
            if (grant) begin
                m_ov  = 1;
                m_od  = int'(p_d);
                m_sel = onehot(w);
                m_ptr = (w + 1) % WAYS;
            end else if (o_r) begin
                m_ov = 0;
            end
        end
        #1;
        chk("o_v", int'(o_v), int'(m_ov));
        if (m_ov || m_was_rst) begin
            chk("o_d", int'(o_d), m_od);
            chk("o_sel", int'(o_sel), m_sel);
        end
        chk("o_cnt", int'(o_cnt), m_cnt);
        chk("o_err", int'(o_err), int'(m_err));
    endtask

    typedef struct {
        bit rst; int req; bit pv; int pd; bit orr; bit fv; int fd; bit rr;
        int x_reqr; bit x_fr; bit x_rv; bit x_ov; int x_sel; int x_od; int x_cnt; bit x_err;
    } vec_t;

    function automatic vec_t mk(input bit rst, input int req, input bit pv, input int pd, input bit orr,
                                input bit fv, input int fd, input bit rr,
                                input int x_reqr, input bit x_fr, input bit x_rv,
                                input bit x_ov, input int x_sel, input int x_od, input int x_cnt,
                                input bit x_err);
        vec_t v;
        v.rst = rst; v.req = req; v.pv = pv; v.pd = pd; v.orr = orr; v.fv = fv; v.fd = fd; v.rr = rr;
        v.x_reqr = x_reqr; v.x_fr = x_fr; v.x_rv = x_rv; v.x_ov = x_ov;
        v.x_sel = x_sel; v.x_od = x_od; v.x_cnt = x_cnt; v.x_err = x_err;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   free_tags[$];
        int   used_tags[$];

        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //           rst req      pv pd orr fv fd rr  reqr fr rv  ov sel od cnt err
        tbl.push_back(mk(1, 'hF,     1, 0,  1, 1, 0, 1,  0,   0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'hF,     1, 0,  1, 0, 0, 0,  8,   0, 0,  1, 8, 0, 1, 0));
        tbl.push_back(mk(0, 'hF,     1, 1,  1, 0, 0, 0,  4,   0, 0,  1, 4, 1, 2, 0));
        tbl.push_back(mk(0, 'hF,     1, 2,  1, 0, 0, 0,  2,   0, 0,  1, 2, 2, 3, 0));
        tbl.push_back(mk(0, 'hF,     1, 3,  1, 0, 0, 0,  1,   0, 0,  1, 1, 3, 4, 0));
        tbl.push_back(mk(0, 'hF,     1, 4,  1, 0, 0, 0,  8,   0, 0,  1, 8, 4, 5, 0));
        tbl.push_back(mk(1, 'hF,     1, 9,  0, 0, 0, 0,  0,   0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'b0110,  1, 5,  1, 0, 0, 0,  4,   0, 0,  1, 4, 5, 1, 0));
        tbl.push_back(mk(0, 0,       0, 0,  1, 1, 5, 1,  0,   1, 1,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0,       0, 0,  1, 1, 5, 1,  0,   1, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0,       0, 0,  1, 0, 0, 0,  0,   0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'b0001,  1, 9,  0, 0, 0, 0,  1,   0, 0,  1, 1, 9, 1, 0));
        tbl.push_back(mk(0, 'hF,     1, 10, 0, 0, 0, 0,  0,   0, 0,  1, 1, 9, 1, 0));
        tbl.push_back(mk(0, 'hF,     1, 10, 0, 0, 0, 0,  0,   0, 0,  1, 1, 9, 1, 0));
        tbl.push_back(mk(0, 'hF,     1, 10, 0, 0, 0, 0,  0,   0, 0,  1, 1, 9, 1, 0));
        tbl.push_back(mk(0, 'hF,     1, 10, 1, 0, 0, 0,  8,   0, 0,  1, 8, 10, 2, 0));
        tbl.push_back(mk(0, 'hF,     1, 2,  1, 0, 0, 0,  4,   0, 0,  1, 4, 2, 3, 0));
        tbl.push_back(mk(0, 'hF,     1, 7,  1, 1, 2, 1,  2,   1, 1,  1, 2, 7, 3, 0));
        tbl.push_back(mk(0, 0,       0, 0,  1, 1, 2, 1,  0,   1, 0,  0, 0, 0, 3, 1));
        tbl.push_back(mk(0, 0,       0, 0,  1, 1, 7, 0,  0,   0, 1,  0, 0, 0, 3, 0));
        tbl.push_back(mk(0, 0,       0, 0,  1, 1, 7, 1,  0,   1, 1,  0, 0, 0, 2, 0));

        foreach (tbl[n]) begin
            @(negedge clk);
            drive(tbl[n].rst, tbl[n].req, tbl[n].pv, tbl[n].pd, tbl[n].orr,
                  tbl[n].fv, tbl[n].fd, tbl[n].rr);
            #1;
            chk($sformatf("t%0d_req_r", n), int'(req_r), tbl[n].x_reqr);
            chk($sformatf("t%0d_r_v", n), int'(r_v), int'(tbl[n].x_rv));
            if (tbl[n].fv || tbl[n].rst) chk($sformatf("t%0d_f_r", n), int'(f_r), int'(tbl[n].x_fr));
            tick();
            chk($sformatf("t%0d_o_v", n), int'(o_v), int'(tbl[n].x_ov));
            if (tbl[n].x_ov || tbl[n].rst) begin
                chk($sformatf("t%0d_o_sel", n), int'(o_sel), tbl[n].x_sel);
                chk($sformatf("t%0d_o_d", n), int'(o_d), tbl[n].x_od);
            end
            chk($sformatf("t%0d_o_cnt", n), int'(o_cnt), tbl[n].x_cnt);
            chk($sformatf("t%0d_o_err", n), int'(o_err), int'(tbl[n].x_err));
        end

        // Fill the whole pool, stall on an empty pool, then free one tag.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int t = 0; t < NRES; t++) begin
            @(negedge clk);
            drive(0, 'hF, 1, t, 1, 0, 0, 0);
            tick();
        end
        chk("fill_cnt", int'(o_cnt), NRES);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            drive(0, 'hF, 0, 0, 1, 0, 0, 0);
            #1;
            chk("stall_req_r", int'(req_r), 0);
            tick();
        end
        @(negedge clk);
        drive(0, 'hF, 0, 0, 1, 1, 3, 1);
        #1;
        chk("free3_r_v", int'(r_v), 1);
        chk("free3_r_d", int'(r_d), 3);
        tick();
        chk("free3_cnt", int'(o_cnt), NRES - 1);

        // Random traffic with a well-behaved pool that only offers tags not in use.
        for (int c = 0; c < 3000; c++) begin
            bit rst, pv, fv;
            int pd, fd;
            @(negedge clk);
            free_tags.delete();
            used_tags.delete();
            for (int t = 0; t < NRES; t++) begin
                if (m_inuse[t]) used_tags.push_back(t);
                else            free_tags.push_back(t);
            end
            rst = ($urandom_range(0, 199) == 0);
            pv  = (free_tags.size() > 0) && ($urandom_range(0, 3) != 0);
            pd  = pv ? free_tags[$urandom_range(0, free_tags.size() - 1)] : int'($urandom_range(0, NRES - 1));
            fv  = ($urandom_range(0, 2) == 0);
            if (used_tags.size() > 0 && $urandom_range(0, 4) != 0)
                fd = used_tags[$urandom_range(0, used_tags.size() - 1)];
            else
                fd = int'($urandom_range(0, NRES - 1));
            drive(rst, int'($urandom_range(0, 15)), pv, pd, ($urandom_range(0, 2) != 0),
                  fv, fd, bit'($urandom_range(0, 1)));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
